// File: rtl/lpddr2_responder_if.sv
// Requester-side bus for the LPDDR2 responder: one outstanding read or write,
// level-sensitive requests, registered completion signals.
interface lpddr2_responder_if;
    logic [26:0] address;
    logic [31:0] write_data;
    logic        rreq;
    logic        wreq;
    logic [31:0] read_data;
    logic        busy;
    logic        ack;
    logic        err;

    modport master (
        output address, write_data, rreq, wreq,
        input  read_data, busy, ack, err
    );

    modport slave (
        input  address, write_data, rreq, wreq,
        output read_data, busy, ack, err
    );
endinterface

// File: rtl/lpddr2_responder.sv
// Fixed-latency word memory responder: accepts one read/write at a time,
// completes LATENCY cycles after accept with an ack pulse.
//
// state | meaning
// IDLE  | waiting for exactly one of rreq/wreq
// WAIT  | request captured, latency counter running
// DONE  | final cycle; commit/read happens on the edge back to IDLE
module lpddr2_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 4,
    parameter logic [31:0] OOR_DATA = 32'hDEADBEEF
) (
    input  logic         clk,
    input  logic         rst_n,
    lpddr2_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [26:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_wr_q, is_wr_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mem_we;
    logic        oor;

    // Storage is deliberately outside the reset domain; contents survive rst_n.
    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    assign oor = (addr_q >> ADDR_W) != 27'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 27'd0;
            wdata_q <= 32'd0;
            is_wr_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[ADDR_W-1:0]] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.rreq ^ bus.wreq) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    is_wr_d = bus.wreq;
                    busy_d  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? DONE : WAIT;
                end else if (bus.rreq && bus.wreq) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ack_d   = 1'b1;
                err_d   = oor;
                if (is_wr_q) begin
                    mem_we = !oor;
                end else begin
                    rdata_d = oor ? OOR_DATA : mem_q[addr_q[ADDR_W-1:0]];
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.read_data = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;

endmodule

// File: doc/lpddr2_responder.md
LPDDR2_RESPONDER -- requirements
Module: lpddr2_responder

Interface
REQ-001 Parameter ADDR_W, default 10: number of word-address bits decoded; storage depth is 2^ADDR_W 32-bit words.
REQ-002 Parameter LATENCY, default 4: cycles from request accept to completion; legal range 1..15.
REQ-003 Parameter OOR_DATA, default 32'hDEADBEEF: read data returned for out-of-range addresses.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 address  input  27  word address from requester.
REQ-007 write_data  input  32  write data from requester.
REQ-008 rreq  input  1  read request, level-sensitive.
REQ-009 wreq  input  1  write request, level-sensitive.
REQ-010 read_data  output  32  data of the last completed read.
REQ-011 busy  output  1  high from accept until completion.
REQ-012 ack  output  1  one-cycle completion pulse for a read or a write.
REQ-013 err  output  1  one-cycle pulse on a protocol or range error.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, DONE; reset state is IDLE.
REQ-015 In IDLE, on a rising edge with exactly one of rreq/wreq high, the block SHALL capture address, write_data and request type, set busy=1, load a counter with LATENCY-1, and enter WAIT (LATENCY>1) or DONE (LATENCY=1).
REQ-016 In WAIT, the counter SHALL decrement each cycle; at 1 the FSM SHALL enter DONE on the next edge.
REQ-017 On the edge leaving DONE for IDLE, the block SHALL commit the write or update read_data, pulse ack for exactly one cycle, and clear busy.
REQ-018 A request accepted at edge k SHALL show ack=1 and busy=0 in the cycle following edge k+LATENCY.
REQ-019 Captured values SHALL be used; changes on address, write_data, rreq or wreq while busy=1 SHALL be ignored.
REQ-020 A request still high in the cycle after ack SHALL be accepted as a new request; the requester SHALL deassert it in the ack cycle to avoid a repeat.
REQ-021 If rreq and wreq are both high in IDLE, the block SHALL accept nothing, pulse err for one cycle, and stay in IDLE.
REQ-022 An address with any bit above ADDR_W-1 set SHALL be out of range: a write is dropped and a read returns OOR_DATA; both still complete with normal latency and ack, plus err in the ack cycle.
REQ-023 read_data SHALL change only on read completion and SHALL hold its value across writes and idle cycles.
REQ-024 A write followed by a read of the same address SHALL return the written data (no bypass is needed; requests are serialized).
REQ-025 ack and err SHALL never be high for more than one consecutive cycle per event.

Reset
REQ-026 With rst low, the block SHALL force state=IDLE, busy=0, ack=0, err=0, read_data=0 and counter=0 immediately, without waiting for a clock edge.
REQ-027 A reset during WAIT or DONE SHALL abort the request: a pending write is not committed and no ack is produced.
REQ-028 Storage contents SHALL NOT be cleared by reset; simulation SHALL initialize storage to zero.
REQ-029 After rst rises, the first accept SHALL occur no earlier than the first rising edge on which rst is high.

Verification
REQ-030 Write 0x0000_0005 <- 0xCAFEBABE with LATENCY=4, then read 0x5 -> each op shows ack 4 cycles after accept; read_data=0xCAFEBABE.
REQ-031 rreq and wreq both high in IDLE -> err pulses once, busy stays 0, no ack, storage unchanged.
REQ-032 Read address 0x0000_0400 (ADDR_W=10) -> ack with err, read_data=0xDEADBEEF; a write to 0x400 leaves word 0x000 unchanged.
REQ-033 Write to 0x3 accepted, rst pulsed low in WAIT, then read 0x3 -> returns 0x00000000; no ack for the aborted write; busy drops asynchronously.
REQ-034 Hold rreq high continuously at address 0x1 -> back-to-back reads with one ack every LATENCY+1 cycles; address changes while busy do not affect the returned data.
REQ-035 LATENCY=1: write then read 0x3FF <- 0x12345678 -> ack in the cycle after each accept; read_data=0x12345678.
